// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a one-entry valid/ready result register
// and an iterative shift-add multiplier that stalls the input side for WIDTH cycles.
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_res, acc_next;
    logic             accept, defined, slt;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign slt      = $signed(op_a) < $signed(op_b);
    assign defined  = alu_control inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL};
    // Undefined codes fall through to zero so the zero flag follows naturally.
    assign alu_res  = (alu_control == OP_ADD) ? op_a + op_b :
                      (alu_control == OP_SUB) ? op_a - op_b :
                      (alu_control == OP_AND) ? op_a & op_b :
                      (alu_control == OP_OR)  ? op_a | op_b :
                      (alu_control == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt} : '0;
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (state_q == IDLE && accept) begin
            if (alu_control == OP_MUL) begin
                state_d  = MUL;
                mcand_d  = op_a;
                mplier_d = op_b;
                acc_d    = '0;
                cnt_d    = CNT_W'(WIDTH);
            end else begin
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                illegal_d   = !defined;
                out_valid_d = 1'b1;
            end
        end else if (state_q == MUL) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d     = IDLE;
                result_d    = acc_next;
                zero_d      = (acc_next == '0);
                illegal_d   = 1'b0;
                out_valid_d = 1'b1;
            end
        end
        busy_d = (state_d == MUL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; the driver pushes reference results on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_exec_unit;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_control = 4'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic         busy;

    alu_exec_unit #(.WIDTH(W), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operation; visible cycle is the accept
    // cycle plus one, plus WIDTH more edges for multiply.
    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int t);
        exp_t e;
        e.ill = 1'b0;
        case (c)
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1100: e.res = a * b;
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.z   = (e.res == '0);
        e.cyc = t + 1 + ((c == 4'b1100) ? W : 0);
        return e;
    endfunction

    logic prev_v = 1'b0;
    logic prev_ret = 1'b0;
    int   vis = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!prev_v || prev_ret) vis = cyc;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("zero", W'(zero), W'(e.z));
                    chk("illegal", W'(illegal), W'(e.ill));
                    chk("latency", W'(vis), W'(e.cyc));
                end
            end
        end
        prev_v   = rst_n && out_valid;
        prev_ret = rst_n && out_valid && out_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        alu_control = c;
        op_a = a;
        op_b = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(c, a, b, cyc));
                tick();
                break;
            end
            tick();
            if (++n > 300) begin
                chk("issue_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) tick();
        chk("drain_empty", W'(sb.size()), 0);
    endtask

    initial begin
        logic [3:0] codes [7];
        logic [3:0] c;
        logic [W-1:0] a, b;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101};

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'(i);
            @(negedge clk);
            chk("rst_out_valid", W'(out_valid), 0);
            chk("rst_result", result, 0);
            chk("rst_busy", W'(busy), 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        tick();

        out_ready = 1'b1;
        issue(4'b0010, 5, 7);
        issue(4'b0110, 3, 5);
        issue(4'b0000, 64'hF0, 64'h3C);
        issue(4'b0001, 64'hF0, 64'h0F);
        issue(4'b0111, '1, 1);
        issue(4'b0111, 1, '1);
        issue(4'b0110, 9, 9);
        issue(4'b0101, 11, 22);
        drain();

        issue(4'b1100, 64'h1_0000_0003, 6);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i);
            alu_control = 4'b0010;
            op_a = {$urandom, $urandom};
            @(negedge clk);
            chk("mul_busy", W'(busy), 1);
            chk("mul_in_ready", W'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        drain();
        issue(4'b1100, '1, 2);
        drain();

        out_ready = 1'b0;
        issue(4'b0010, 100, 23);
        in_valid = 1'b1;
        alu_control = 4'b0110;
        op_a = 50;
        op_b = 8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", W'(in_ready), 0);
            chk("hold_result", result, 123);
            chk("hold_valid", W'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        issue(4'b0110, 50, 8);
        drain();

        issue(4'b1100, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (20) tick();
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_busy", W'(busy), 0);
        chk("async_rst_valid", W'(out_valid), 0);
        chk("async_rst_result", result, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            chk("no_stale_result", W'(out_valid), 0);
            tick();
        end
        issue(4'b0010, 1, 1);
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            c = codes[$urandom_range(0, 6)];
            if (c == 4'b1100 && $urandom_range(0, 2) != 0) c = 4'b0010;
            if (c == 4'b0101) c = 4'($urandom);
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) b = W'($urandom_range(0, 3));
            issue(c, a, b);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rdy = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU consuming the 4-bit alu_control code produced by ALU_CONTROL, plus two operands; returns a registered result with a zero flag.
- Single-cycle ops (add, sub, and, or, slt) complete in 1 cycle. An iterative shift-add multiply (code 1100) takes WIDTH cycles.
- Valid/ready handshakes on both sides; one-entry output register. This lets the unit sit between decode and writeback, and lets the multi-cycle multiply stall the pipe.

Parameters:
- WIDTH, 64, operand and result width in bits (even, >= 8)
- CNT_W, 7, multiply iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- alu_control  input  4  operation code
- op_a  input  WIDTH  operand A (rs1)
- op_b  input  WIDTH  operand B (rs2/imm)
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- zero  output  1  registered flag, 1 when result == 0
- illegal  output  1  registered flag, 1 when alu_control was not a defined code
- busy  output  1  1 while in MUL state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0, counter=0, multiply accumulators=0. Recovery is on the first rising clk after rst_n rises.
- Codes:
  - 0010 add: A+B mod 2^WIDTH.
  - 0110 sub: A-B mod 2^WIDTH, wrap-around, no flag.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed compare, result = {0...,1} if $signed(A)<$signed(B), else 0.
  - 1100 mul: low WIDTH bits of A*B (unsigned == signed low half).
  - Any other code: result=0, zero=1, illegal=1, single-cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge.
- FSM states: IDLE, MUL.
  - IDLE: on accept of a non-mul code, result/zero/illegal load at the same edge; out_valid=1 from the next cycle (latency 1).
  - IDLE: on accept of 1100, latch A into the multiplicand, B into the multiplier, clear the accumulator, set counter=WIDTH, and go to MUL. If out_valid && out_ready at that edge, out_valid clears.
  - MUL: each edge, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter -= 1. in_valid is ignored (in_ready=0).
  - MUL: on the edge where counter goes 1->0, load result = final acc, zero, illegal=0, out_valid=1, and return to IDLE. MUL result is visible exactly WIDTH cycles after the accept edge.
  - MUL never starts writing while out_valid=1 is pending. Entry to MUL already requires the output slot to be freed by in_ready.
- Output hold: while out_valid && !out_ready, result/zero/illegal are stable and in_ready=0.
- Simultaneous out_ready and accept of a single-cycle op: the old result retires and the new result loads at the same edge. out_valid stays 1, giving a back-to-back throughput of 1/cycle.
- out_valid && out_ready with no accept: out_valid clears next cycle; result holds its last value.
- Operands and alu_control are sampled only at the accept edge. Later changes have no effect.
- Reset asserted mid-MUL: the operation is abandoned, and all state and outputs return to reset values immediately (asynchronously). No result is emitted.
- busy = (state==MUL), registered.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 while toggling in_valid; release.
  - Response: out_valid=0, result=0, busy=0 throughout reset; in_ready=1 on the first cycle after release.
- Back-to-back single-cycle ops, out_ready=1 (WIDTH=64):
  - add 5+7 -> 12;
  - sub 3-5 -> 0xFFFF_FFFF_FFFF_FFFE;
  - and 0xF0&0x3C -> 0x30;
  - or 0xF0|0x0F -> 0xFF;
  - slt(-1,1) -> 1;
  - slt(1,-1) -> 0;
  - each result appears 1 cycle after its accept, with out_valid continuously 1 and zero=0.
- Zero/illegal:
  - sub 9-9 -> result 0, zero=1, illegal=0;
  - code 0101 -> result 0, zero=1, illegal=1, latency 1.
- Multiply:
  - mul 0x1_0000_0003 * 6 -> 0x6_0000_0012 exactly 64 cycles after accept;
  - mul 0xFFFF_FFFF_FFFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE;
  - during the operation busy=1 and in_ready=0, and in_valid pulses are ignored.
- Backpressure:
  - Hold out_ready=0 after an add, with in_valid=1 carrying a second op.
  - Response: result is stable and in_ready=0 for 5 cycles. When out_ready is raised, the first result retires and the second op is accepted at the same edge. Its result follows 1 cycle later.
- Reset mid-MUL:
  - Assert rst_n=0 20 cycles into a multiply.
  - Response: busy, out_valid, and result drop to 0 immediately. After release no stale result appears, and a new add 1+1 -> 2 completes normally.
